// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared FSM/grant types and constants for the BRAM frame arbiter
package bram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WR,
    GNT_RD
  } gnt_e;

  localparam logic [3:0] WEB_ALL = 4'hF;

endpackage

// File: rtl/bram_rd_pipe.sv
// rtl/bram_rd_pipe.sv - in-flight read tracker: shifts {valid, err} so the tail lines up with doutb
module bram_rd_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic err_i,
  output logic valid_o,
  output logic err_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      err_q   <= '0;
    end else begin
      valid_q <= {valid_q[DEPTH-2:0], push_i};
      err_q   <= {err_q[DEPTH-2:0], push_i & err_i};
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign err_o   = err_q[DEPTH-1];

endmodule

// File: rtl/bram_frame_arbiter.sv
// rtl/bram_frame_arbiter.sv - frame writer + readback arbiter on BRAM port B
// Optional ARB_WR_PRIORITY_EN: writes always win a conflict instead of round-robin.
module bram_frame_arbiter
  import bram_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4300_0000,
  parameter int          DIM_W     = 11,
  parameter int          NW_W      = 17,
  parameter int          RD_LAT    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             frame_abort,
  input  logic [DIM_W-1:0] h,
  input  logic [DIM_W-1:0] w,
  input  logic             wr_valid,
  input  logic [31:0]      wr_data,
  output logic             wr_ready,
  input  logic             rd_req,
  input  logic [NW_W-1:0]  rd_addr,
  output logic             rd_ready,
  output logic             rd_valid,
  output logic [31:0]      rd_data,
  output logic             rd_err,
  output logic             frame_busy,
  output logic             frame_done,
  output logic             clkb,
  output logic             rstb,
  output logic             enb,
  output logic [3:0]       web,
  output logic [31:0]      addrb,
  output logic [31:0]      dinb,
  input  logic [31:0]      doutb
);

  function automatic logic [31:0] word_addr(input logic [NW_W-1:0] idx);
    return BASE_ADDR + 32'({idx, 2'b00});
  endfunction

  state_e           state_q, state_d;
  gnt_e             gnt;
  logic [DIM_W-1:0] h_q, w_q;
  logic [NW_W-1:0]  nwords_q, nwords_d, wr_cnt_q, wr_cnt_d, nwords_calc;
  logic [2*DIM_W-1:0] area, area_rnd;
  logic             wr_req, rd_ok, rd_oor;
  logic             enb_q, rstb_q;
  logic [3:0]       web_q;
  logic [31:0]      addrb_q, dinb_q;

  assign area        = {{DIM_W{1'b0}}, h_q} * {{DIM_W{1'b0}}, w_q};
  assign area_rnd    = area + (2*DIM_W)'(31);
  assign nwords_calc = NW_W'(area_rnd >> 5);

  assign wr_req = wr_valid && (state_q == RUN) && !frame_abort;
  assign rd_ok  = rd_req && (state_q != LOAD);
  assign rd_oor = rd_addr >= nwords_q;

`ifdef ARB_WR_PRIORITY_EN
  always_comb begin
    gnt = GNT_NONE;
    if (wr_req)     gnt = GNT_WR;
    else if (rd_ok) gnt = GNT_RD;
  end
`else
  logic last_rd_q;

  // Conflicts go to whichever side lost the previous grant.
  always_comb begin
    gnt = GNT_NONE;
    if (wr_req && rd_ok) gnt = last_rd_q ? GNT_WR : GNT_RD;
    else if (wr_req)     gnt = GNT_WR;
    else if (rd_ok)      gnt = GNT_RD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 last_rd_q <= 1'b1;
    else if (gnt == GNT_WR)  last_rd_q <= 1'b0;
    else if (gnt == GNT_RD)  last_rd_q <= 1'b1;
  end
`endif

  always_comb begin
    state_d  = state_q;
    nwords_d = nwords_q;
    wr_cnt_d = wr_cnt_q;
    case (state_q)
      IDLE: if (frame_start && !frame_abort) state_d = LOAD;
      LOAD: begin
        nwords_d = nwords_calc;
        wr_cnt_d = '0;
        if (frame_abort)            state_d = IDLE;
        else if (nwords_calc == '0) state_d = DONE;
        else                        state_d = RUN;
      end
      RUN: begin
        if (frame_abort) begin
          state_d = IDLE;
        end else if (gnt == GNT_WR) begin
          wr_cnt_d = wr_cnt_q + NW_W'(1);
          if (wr_cnt_q == nwords_q - NW_W'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      nwords_q <= '0;
      wr_cnt_q <= '0;
      h_q      <= '0;
      w_q      <= '0;
    end else begin
      state_q  <= state_d;
      nwords_q <= nwords_d;
      wr_cnt_q <= wr_cnt_d;
      if (state_q == IDLE && frame_start) begin
        h_q <= h;
        w_q <= w;
      end
    end
  end

  // Port B strobe: registered one cycle after the grant; addr/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstb_q  <= 1'b1;
      enb_q   <= 1'b0;
      web_q   <= '0;
      addrb_q <= BASE_ADDR;
      dinb_q  <= '0;
    end else begin
      rstb_q <= 1'b0;
      enb_q  <= 1'b0;
      web_q  <= '0;
      if (gnt == GNT_WR) begin
        enb_q   <= 1'b1;
        web_q   <= WEB_ALL;
        addrb_q <= word_addr(wr_cnt_q);
        dinb_q  <= wr_data;
      end else if (gnt == GNT_RD && !rd_oor) begin
        enb_q   <= 1'b1;
        addrb_q <= word_addr(rd_addr);
      end
    end
  end

  bram_rd_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_rd_pipe (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (gnt == GNT_RD),
    .err_i   (rd_oor),
    .valid_o (rd_valid),
    .err_o   (rd_err)
  );

  assign rd_data    = (rd_valid && !rd_err) ? doutb : '0;
  assign wr_ready   = (gnt == GNT_WR);
  assign rd_ready   = (gnt == GNT_RD);
  assign frame_busy = (state_q == LOAD) || (state_q == RUN);
  assign frame_done = (state_q == DONE);
  assign clkb       = clk;
  assign rstb       = rstb_q;
  assign enb        = enb_q;
  assign web        = web_q;
  assign addrb      = addrb_q;
  assign dinb       = dinb_q;

endmodule

// File: tb/tb_bram_frame_arbiter.sv
// tb/tb_bram_frame_arbiter.sv - directed scoreboard bench for bram_frame_arbiter with a BRAM port model
module tb_bram_frame_arbiter;

  localparam logic [31:0] BASE = 32'h4300_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start, frame_abort;
  logic [10:0] h, w;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        rd_req;
  logic [16:0] rd_addr;
  logic        rd_ready, rd_valid, rd_err;
  logic [31:0] rd_data;
  logic        frame_busy, frame_done;
  logic        clkb, rstb, enb;
  logic [3:0]  web;
  logic [31:0] addrb, dinb;
  logic [31:0] doutb = '0;

  bram_frame_arbiter dut (
    .clk (clk), .rst (rst), .frame_start (frame_start), .frame_abort (frame_abort),
    .h (h), .w (w), .wr_valid (wr_valid), .wr_data (wr_data), .wr_ready (wr_ready),
    .rd_req (rd_req), .rd_addr (rd_addr), .rd_ready (rd_ready), .rd_valid (rd_valid),
    .rd_data (rd_data), .rd_err (rd_err), .frame_busy (frame_busy), .frame_done (frame_done),
    .clkb (clkb), .rstb (rstb), .enb (enb), .web (web), .addrb (addrb), .dinb (dinb),
    .doutb (doutb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
  } strobe_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } resp_t;

  strobe_t     sq[$];
  resp_t       rq[$];
  strobe_t     ms;
  resp_t       mr;
  int          checks = 0;
  int          errors = 0;
  int          rv_cnt = 0;
  int          nw = 0;
  logic        last_rd = 1'b1;
  logic [31:0] mem    [0:63];
  logic [31:0] shadow [0:63];
  logic [31:0] boff;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle-latency BRAM port model
  assign boff = addrb - BASE;
  always @(posedge clk) begin
    if (enb) begin
      if (web == 4'hF) mem[boff[7:2]] <= dinb;
      else             doutb <= mem[boff[7:2]];
    end
  end

  always @(negedge clk) begin
    #2;
    if (enb) begin
      chk("strobe_expected", {31'b0, sq.size() != 0}, 32'd1);
      if (sq.size() != 0) begin
        ms = sq.pop_front();
        chk("addrb", addrb, ms.addr);
        chk("web", {28'b0, web}, ms.is_wr ? 32'hF : 32'h0);
        if (ms.is_wr) chk("dinb", dinb, ms.data);
      end
    end
    if (rd_valid) begin
      rv_cnt++;
      chk("resp_expected", {31'b0, rq.size() != 0}, 32'd1);
      if (rq.size() != 0) begin
        mr = rq.pop_front();
        chk("rd_data", rd_data, mr.data);
        chk("rd_err", {31'b0, rd_err}, {31'b0, mr.err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_wr(input int idx, input logic [31:0] d);
    sq.push_back('{1'b1, BASE + 32'(idx * 4), d});
    shadow[idx] = d;
    last_rd = 1'b0;
  endtask

  task automatic push_rd(input int idx);
    if (idx < nw) begin
      sq.push_back('{1'b0, BASE + 32'(idx * 4), 32'h0});
      rq.push_back('{1'b0, shadow[idx]});
    end else begin
      rq.push_back('{1'b1, 32'h0});
    end
    last_rd = 1'b1;
  endtask

  // Leaves the bench at the negedge of the LOAD cycle
  task automatic start_frame(input int hh, input int ww);
    h = 11'(hh);
    w = 11'(ww);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    nw = (hh * ww + 31) / 32;
  endtask

  task automatic write_word(input int idx, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    #1;
    chk("wr_ready_run", {31'b0, wr_ready}, 32'd1);
    push_wr(idx, d);
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    int   left;
    int   wcnt;
    int   rv_base;
    logic exp_wr;
    logic done_next;

    for (int i = 0; i < 64; i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end
    rst = 1'b1; frame_start = 1'b0; frame_abort = 1'b0; h = '0; w = '0;
    wr_valid = 1'b0; wr_data = '0; rd_req = 1'b0; rd_addr = '0;
    tick();
    tick();

    chk("rst_enb", {31'b0, enb}, 32'd0);
    chk("rst_web", {28'b0, web}, 32'd0);
    chk("rst_addrb", addrb, BASE);
    chk("rst_dinb", dinb, 32'd0);
    chk("rst_rstb", {31'b0, rstb}, 32'd1);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_rd_err", {31'b0, rd_err}, 32'd0);
    chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
    chk("rst_frame_busy", {31'b0, frame_busy}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rstb_released", {31'b0, rstb}, 32'd0);

    // read before any frame: nwords is 0, so out of range
    rd_req = 1'b1; rd_addr = 17'd0;
    #1;
    chk("rd_ready_idle", {31'b0, rd_ready}, 32'd1);
    push_rd(0);
    tick();
    rd_req = 1'b0;
    tick();
    tick();

    // frame 1: 8x8 -> two words
    start_frame(8, 8);
    rd_req = 1'b1; wr_valid = 1'b1;
    #1;
    chk("rd_ready_load", {31'b0, rd_ready}, 32'd0);
    chk("wr_ready_load", {31'b0, wr_ready}, 32'd0);
    chk("busy_load", {31'b0, frame_busy}, 32'd1);
    rd_req = 1'b0; wr_valid = 1'b0;
    tick();
    write_word(0, 32'h1111_AAAA);
    write_word(1, 32'h2222_BBBB);
    chk("done_f1", {31'b0, frame_done}, 32'd1);
    chk("busy_done_f1", {31'b0, frame_busy}, 32'd0);
    tick();
    chk("done_f1_pulse", {31'b0, frame_done}, 32'd0);

    // frame 2: 5x7 -> ceil(35/32) = 2 words
    start_frame(5, 7);
    tick();
    write_word(0, 32'h3333_CCCC);
    write_word(1, 32'hDEAD_BEEF);
    wr_valid = 1'b1;
    #1;
    chk("wr_ready_third", {31'b0, wr_ready}, 32'd0);
    chk("done_f2", {31'b0, frame_done}, 32'd1);
    tick();
    #1;
    chk("wr_ready_idle", {31'b0, wr_ready}, 32'd0);
    wr_valid = 1'b0;

    // readback latency and out-of-range
    rd_req = 1'b1; rd_addr = 17'd1;
    #1;
    chk("rd_ready_1", {31'b0, rd_ready}, 32'd1);
    push_rd(1);
    tick();
    rd_req = 1'b0;
    chk("rd_enb_1", {31'b0, enb}, 32'd1);
    chk("rd_lat_early", {31'b0, rd_valid}, 32'd0);
    tick();
    chk("rd_lat_valid", {31'b0, rd_valid}, 32'd1);
    chk("rd_lat_data", rd_data, 32'hDEAD_BEEF);
    tick();
    rd_req = 1'b1; rd_addr = 17'd5;
    #1;
    chk("rd_ready_oor", {31'b0, rd_ready}, 32'd1);
    push_rd(5);
    tick();
    rd_req = 1'b0;
    chk("enb_oor", {31'b0, enb}, 32'd0);
    tick();
    chk("oor_valid", {31'b0, rd_valid}, 32'd1);
    chk("oor_err", {31'b0, rd_err}, 32'd1);
    chk("oor_data", rd_data, 32'd0);
    tick();

    // contention: 16x16 -> 8 words, both sides requesting every cycle
    start_frame(16, 16);
    wr_valid = 1'b1; rd_req = 1'b1;
    #1;
    chk("ct_load_wr", {31'b0, wr_ready}, 32'd0);
    chk("ct_load_rd", {31'b0, rd_ready}, 32'd0);
    tick();
    left = nw; wcnt = 0; done_next = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wr_data = 32'h3000_0000 + 32'(i);
      rd_addr = 17'(i % 8);
      #1;
`ifdef ARB_WR_PRIORITY_EN
      exp_wr = (left > 0);
`else
      exp_wr = (left > 0) && last_rd;
`endif
      chk("ct_wr_ready", {31'b0, wr_ready}, {31'b0, exp_wr});
      chk("ct_rd_ready", {31'b0, rd_ready}, {31'b0, !exp_wr});
      chk("ct_frame_done", {31'b0, frame_done}, {31'b0, done_next});
      done_next = 1'b0;
      if (exp_wr) begin
        push_wr(wcnt, wr_data);
        wcnt++;
        left--;
        if (left == 0) done_next = 1'b1;
      end else begin
        push_rd(i % 8);
      end
      tick();
    end
    wr_valid = 1'b0; rd_req = 1'b0;
    tick();
    tick();
    tick();

    // empty frame and abort
    start_frame(0, 9);
    chk("h0_busy", {31'b0, frame_busy}, 32'd1);
    tick();
    chk("h0_done", {31'b0, frame_done}, 32'd1);
    chk("h0_enb", {31'b0, enb}, 32'd0);
    tick();
    chk("h0_done_pulse", {31'b0, frame_done}, 32'd0);
    chk("h0_enb_after", {31'b0, enb}, 32'd0);
    start_frame(8, 8);
    tick();
    write_word(0, 32'h5555_0001);
    frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;
    wr_valid = 1'b1;
    #1;
    chk("abort_busy", {31'b0, frame_busy}, 32'd0);
    chk("abort_wr_ready", {31'b0, wr_ready}, 32'd0);
    chk("abort_no_done", {31'b0, frame_done}, 32'd0);
    wr_valid = 1'b0;
    tick();
    chk("abort_no_done2", {31'b0, frame_done}, 32'd0);

    // reset mid-RUN with two reads in flight
    start_frame(8, 8);
    tick();
    rd_req = 1'b1; rd_addr = 17'd0;
    #1;
    chk("inflight_rd0", {31'b0, rd_ready}, 32'd1);
    push_rd(0);
    tick();
    rd_addr = 17'd1;
    #1;
    chk("inflight_rd1", {31'b0, rd_ready}, 32'd1);
    push_rd(1);
    tick();
    rd_req = 1'b0;
    rst = 1'b1;
    sq.delete();
    rq.delete();
    rv_base = rv_cnt;
    #1;
    chk("mid_rst_enb", {31'b0, enb}, 32'd0);
    chk("mid_rst_web", {28'b0, web}, 32'd0);
    chk("mid_rst_addrb", addrb, BASE);
    chk("mid_rst_dinb", dinb, 32'd0);
    chk("mid_rst_rstb", {31'b0, rstb}, 32'd1);
    chk("mid_rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("mid_rst_rd_data", rd_data, 32'd0);
    chk("mid_rst_busy", {31'b0, frame_busy}, 32'd0);
    chk("mid_rst_done", {31'b0, frame_done}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("no_rd_valid_after_rst", 32'(rv_cnt), 32'(rv_base));

    chk("strobe_q_empty", 32'(sq.size()), 32'd0);
    chk("resp_q_empty", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
